pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor: the sequential, N-bit successor of the single-bit half adder. Splits a WIDTH-bit operation into SEG-bit segments, one per pipeline stage, passing the carry between stages in registers so the clock period stays bounded by a SEG-bit add. A valid/ready handshake on input and output lets it sit inline in a datapath between a producer and a consumer that can stall.

---
 rtl/pipelined_adder_if.sv | 46 ++++
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Handshake and operand bundle for pipelined_adder.
// The slave modport is the adder's view; the master modport is the
// environment's view (producer on the input side, consumer on the output side).
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_cin;
   logic             i_sub;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic             o_ovf;

   modport slave (
      input  i_valid,
      input  i_a,
      input  i_b,
      input  i_cin,
      input  i_sub,
      input  i_ready,
      output o_ready,
      output o_valid,
      output o_sum,
      output o_carry,
      output o_ovf
   );

   modport master (
      output i_valid,
      output i_a,
      output i_b,
      output i_cin,
      output i_sub,
      output i_ready,
      input  o_ready,
      input  o_valid,
      input  o_sum,
      input  o_carry,
      input  o_ovf
   );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor.
// Each stage adds one SEG-bit slice; the slice carry is registered between
// stages. Operands travel with the beat so later stages find their slice,
// and finished low slices travel with it so the whole sum leaves at once.
// The pipeline moves as a single unit: it stalls only when the output
// holds a beat the consumer is not taking.
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input logic i_clk,
   input logic i_rst,
   pipelined_adder_if.slave bus
);
   localparam int STAGES = WIDTH / SEG;

   logic en;

   // Inputs presented to stage k: index 0 comes from the bus, index k>0
   // from the registers of stage k-1.
   logic [WIDTH-1:0] a_in [STAGES];
   logic [WIDTH-1:0] b_in [STAGES];
   logic [WIDTH-1:0] s_in [STAGES];
   logic             c_in [STAGES];
   logic             v_in [STAGES];

   logic             valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             ovf_q;

   assign en          = !(valid_q && !bus.i_ready);
   assign bus.o_ready = en;
   assign bus.o_valid = valid_q;
   assign bus.o_sum   = sum_q;
   assign bus.o_carry = carry_q;
   assign bus.o_ovf   = ovf_q;

   // Subtraction is A + ~B + ~borrow; the borrow inversion folds into one xor.
   assign a_in[0] = bus.i_a;
   assign b_in[0] = bus.i_sub ? ~bus.i_b : bus.i_b;
   assign c_in[0] = bus.i_sub ^ bus.i_cin;
   assign v_in[0] = bus.i_valid;
   assign s_in[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] s_nxt;

      assign seg_sum = {1'b0, a_in[k][k*SEG +: SEG]}
                     + {1'b0, b_in[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_in[k]};

      // Merge this stage's slice into the partial sum carried by the beat.
      always_comb begin
         s_nxt                = s_in[k];
         s_nxt[k*SEG +: SEG]  = seg_sum[SEG-1:0];
      end

      if (k < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;
         logic [WIDTH-1:0] s_q;
         logic             c_q;
         logic             v_q;

         // Stage register: operands (skew), partial sum (deskew), slice carry, valid.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               a_q <= '0;
               b_q <= '0;
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (en) begin
               a_q <= a_in[k];
               b_q <= b_in[k];
               s_q <= s_nxt;
               c_q <= seg_sum[SEG];
               v_q <= v_in[k];
            end
         end

         assign a_in[k+1] = a_q;
         assign b_in[k+1] = b_q;
         assign s_in[k+1] = s_q;
         assign c_in[k+1] = c_q;
         assign v_in[k+1] = v_q;
      end else begin : g_last
         // Output register: full sum, top carry, and signed overflow of the beat.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               valid_q <= 1'b0;
               sum_q   <= '0;
               carry_q <= 1'b0;
               ovf_q   <= 1'b0;
            end else if (en) begin
               valid_q <= v_in[k];
               sum_q   <= s_nxt;
               carry_q <= seg_sum[SEG];
               ovf_q   <= (a_in[k][WIDTH-1] == b_in[k][WIDTH-1])
                       && (s_nxt[WIDTH-1] != a_in[k][WIDTH-1]);
            end
         end
      end
   end
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 16-bit/4-bit-slice instance and an
// 8-bit single-stage instance share clock and reset.
module tb_pipelined_adder;
   logic i_clk = 1'b0;
   logic i_rst;

   always #5 i_clk = ~i_clk;

   pipelined_adder_if #(.WIDTH(16)) bus16 ();
   pipelined_adder_if #(.WIDTH(8))  bus8 ();

   pipelined_adder #(.WIDTH(16), .SEG(4)) u_dut16 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus16));
   pipelined_adder #(.WIDTH(8),  .SEG(8)) u_dut8  (.i_clk(i_clk), .i_rst(i_rst), .bus(bus8));

   typedef struct {
      logic [15:0] sum;
      logic        carry;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_lat = 1'b1;
   bit bp16    = 1'b0;

   bit          stall [2];
   logic [15:0] hsum  [2];
   logic        hcar  [2];
   logic        hovf  [2];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected event expected none (t=%0t)", name, $time);
   endtask

   function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
      exp_t e;
      e.sum = s; e.carry = c; e.ovf = o; e.acc = 0;
      return e;
   endfunction

   // Reference: integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      longint m, ua, ub, full, sa, sb, sr;
      exp_t e;
      m  = longint'(1) << w;
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      full = sub ? (ua - ub - longint'(cin)) : (ua + ub + longint'(cin));
      e.carry = sub ? (full >= 0) : (full >= m);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sr = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
      e.ovf = (sr < -(m / 2)) || (sr >= m / 2);
      full = ((full % m) + m) % m;
      e.sum = 16'(full);
      e.acc = 0;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input exp_t e);
      int guard = 0;
      bit ok = 1'b0;
      if (wide) begin
         bus16.i_a = a; bus16.i_b = b; bus16.i_cin = cin; bus16.i_sub = sub; bus16.i_valid = 1'b1;
      end else begin
         bus8.i_a = a[7:0]; bus8.i_b = b[7:0]; bus8.i_cin = cin; bus8.i_sub = sub; bus8.i_valid = 1'b1;
      end
      while (!ok && guard < 500) begin
         @(negedge i_clk);
         if (wide ? bus16.o_ready : bus8.o_ready) ok = 1'b1;
         else begin
            guard++;
            @(posedge i_clk); #1;
         end
      end
      if (ok) begin
         e.acc = cyc + 1;
         if (wide) q16.push_back(e); else q8.push_back(e);
         @(posedge i_clk); #1;
      end else fail_now("accept_timeout");
      if (wide) bus16.i_valid = 1'b0; else bus8.i_valid = 1'b0;
   endtask

   task automatic send_rand(input bit wide);
      logic [15:0] a, b;
      logic cin, sub;
      a = 16'($urandom); b = 16'($urandom);
      if (!wide) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      send(wide, a, b, cin, sub, model(wide ? 16 : 8, a, b, cin, sub));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic drain(input bit wide);
      int guard = 0;
      while ((wide ? q16.size() : q8.size()) != 0 && guard < 1000) begin
         @(posedge i_clk);
         guard++;
      end
      if (guard >= 1000) fail_now(wide ? "w16_drain_timeout" : "w8_drain_timeout");
      idle(3);
   endtask

   task automatic check_reset_outputs(input bit wide);
      if (wide) begin
         check("w16_rst_valid", bus16.o_valid, 0);
         check("w16_rst_sum",   bus16.o_sum,   0);
         check("w16_rst_carry", bus16.o_carry, 0);
         check("w16_rst_ovf",   bus16.o_ovf,   0);
         check("w16_rst_ready", bus16.o_ready, 1);
      end else begin
         check("w8_rst_valid", bus8.o_valid, 0);
         check("w8_rst_sum",   bus8.o_sum,   0);
         check("w8_rst_carry", bus8.o_carry, 0);
         check("w8_rst_ovf",   bus8.o_ovf,   0);
         check("w8_rst_ready", bus8.o_ready, 1);
      end
   endtask

   // Three beats in flight, then reset: outputs clear at once, nothing stale later.
   task automatic reset_midflight(input bit wide);
      repeat (3) send_rand(wide);
      i_rst = 1'b1;
      #1;
      check_reset_outputs(wide);
      q16.delete();
      q8.delete();
      idle(2);
      i_rst = 1'b0;
      @(negedge i_clk);
      check(wide ? "w16_post_rst_valid" : "w8_post_rst_valid",
            wide ? bus16.o_valid : bus8.o_valid, 0);
      idle(6);
      send_rand(wide);
      drain(wide);
   endtask

   // Output-side checks for one instance, evaluated on the falling edge.
   task automatic mon(input bit wide);
      logic v, r, rdy, c, o;
      logic [15:0] s, mask;
      exp_t e;
      int idx;
      string tag;
      idx  = wide ? 1 : 0;
      tag  = wide ? "w16" : "w8";
      mask = wide ? 16'hFFFF : 16'h00FF;
      if (wide) begin
         v = bus16.o_valid; r = bus16.i_ready; rdy = bus16.o_ready;
         c = bus16.o_carry; o = bus16.o_ovf; s = bus16.o_sum;
      end else begin
         v = bus8.o_valid; r = bus8.i_ready; rdy = bus8.o_ready;
         c = bus8.o_carry; o = bus8.o_ovf; s = {8'h00, bus8.o_sum};
      end
      if (i_rst) begin
         stall[idx] = 1'b0;
         return;
      end
      check({tag, "_o_ready"}, rdy, (v && !r) ? 0 : 1);
      if (stall[idx]) begin
         check({tag, "_hold_valid"}, v, 1);
         check({tag, "_hold_data"}, {c, o, s}, {hcar[idx], hovf[idx], hsum[idx]});
      end
      stall[idx] = v && !r;
      hsum[idx] = s; hcar[idx] = c; hovf[idx] = o;
      if (v && r) begin
         if ((wide ? q16.size() : q8.size()) == 0) fail_now({tag, "_unexpected_output"});
         else begin
            e = wide ? q16.pop_front() : q8.pop_front();
            check({tag, "_sum"},   s, e.sum & mask);
            check({tag, "_carry"}, c, e.carry);
            check({tag, "_ovf"},   o, e.ovf);
            if (chk_lat) check({tag, "_latency"}, cyc - e.acc, wide ? 3 : 0);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge i_clk);
         mon(1'b1);
         mon(1'b0);
      end
   end

   // Consumer: always ready, or coin-flip ready during the backpressure phase.
   initial begin
      bus16.i_ready = 1'b1;
      bus8.i_ready  = 1'b1;
      forever begin
         @(posedge i_clk); #1;
         bus16.i_ready = bp16 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      fail_now("global_timeout");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      i_rst = 1'b1;
      bus16.i_valid = 1'b0; bus16.i_a = '0; bus16.i_b = '0; bus16.i_cin = 1'b0; bus16.i_sub = 1'b0;
      bus8.i_valid  = 1'b0; bus8.i_a  = '0; bus8.i_b  = '0; bus8.i_cin  = 1'b0; bus8.i_sub  = 1'b0;
      idle(3);
      check_reset_outputs(1'b1);
      check_reset_outputs(1'b0);
      i_rst = 1'b0;
      idle(2);

      // Directed 16-bit beats, one at a time.
      send(1, 16'h0001, 16'hFFFF, 0, 0, mk(16'h0000, 1, 0)); drain(1);
      send(1, 16'h7FFF, 16'h0001, 0, 0, mk(16'h8000, 0, 1)); drain(1);
      send(1, 16'h0FFF, 16'h0000, 1, 0, mk(16'h1000, 0, 0)); drain(1);
      send(1, 16'h0005, 16'h0007, 0, 1, mk(16'hFFFE, 0, 0)); drain(1);
      send(1, 16'h8000, 16'h0001, 0, 1, mk(16'h7FFF, 1, 1)); drain(1);

      // Back-to-back stream, consumer always ready.
      for (int i = 0; i < 32; i++) send_rand(1);
      drain(1);

      // Backpressure and input gaps.
      chk_lat = 1'b0;
      bp16    = 1'b1;
      for (int i = 0; i < 150; i++) begin
         send_rand(1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain(1);
      bp16 = 1'b0;
      idle(2);
      drain(1);
      chk_lat = 1'b1;

      reset_midflight(1'b1);

      // Single-stage 8-bit instance.
      send(0, 16'h007F, 16'h0001, 0, 0, mk(16'h0080, 0, 1)); drain(0);
      send(0, 16'h00FF, 16'h0001, 0, 0, mk(16'h0000, 1, 0)); drain(0);
      send(0, 16'h0005, 16'h0007, 0, 1, mk(16'h00FE, 0, 0)); drain(0);
      for (int i = 0; i < 20; i++) send_rand(0);
      drain(0);

      reset_midflight(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
